serial_tx_sched: RTL and testbench

- Round-robin scheduler that shares one 48-bit, 6-byte UART frame transmitter among NUM_REQ frame producers, such as sensor or counter channels.
- Captures one requester's frame, issues a single-cycle new_data strobe to the transmitter, tracks the transmitter's busy through the whole frame, then enforces a minimum inter-frame gap.
- Provides a busy-timeout error flag and a frame counter for host status.

---
 rtl/serial_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_serial_tx_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler sharing one 48-bit UART frame transmitter
// among NUM_REQ producers, with busy watchdog and inter-frame gap.
module serial_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 100,
  parameter int BUSY_TIMEOUT = 8,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [48*NUM_REQ-1:0] req_data,
  input  logic                  pause,
  input  logic                  tx_busy,
  output logic                  tx_new_data,
  output logic [47:0]           tx_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [ID_W-1:0]       grant_id,
  output logic                  frame_active,
  output logic [15:0]           frame_cnt,
  output logic                  err_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int WW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [WW-1:0] WD_LAST  = WW'(BUSY_TIMEOUT - 1);

  logic [2:0]               state_q, state_d;
  logic [ID_W-1:0]          last_grant_q, last_grant_d;
  logic [ID_W-1:0]          grant_id_q, grant_id_d;
  logic [47:0]              tx_data_q, tx_data_d;
  logic                     tx_new_data_q, tx_new_data_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic                     frame_active_q, frame_active_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;
  logic                     err_timeout_q, err_timeout_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [WW-1:0]            wd_q, wd_d;

  logic [NUM_REQ-1:0][47:0] req_arr;
  logic                     pick_vld;
  logic [ID_W-1:0]          pick_id;
  logic                     to_gap;
  int                       idx;

  assign req_arr = req_data;

  // Scan from farthest to nearest so the first set request after
  // last_grant is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (req[ID_W'(idx)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_id_d     = grant_id_q;
    tx_data_d      = tx_data_q;
    tx_new_data_d  = 1'b0;
    ack_d          = '0;
    frame_active_d = frame_active_q;
    frame_cnt_d    = frame_cnt_q;
    err_timeout_d  = err_timeout_q;
    gap_d          = gap_q;
    wd_d           = wd_q;
    to_gap         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!pause && !tx_busy && pick_vld) begin
          state_d        = S_LAUNCH;
          tx_data_d      = req_arr[pick_id];
          grant_id_d     = pick_id;
          last_grant_d   = pick_id;
          tx_new_data_d  = 1'b1;
          ack_d[pick_id] = 1'b1;
          frame_active_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wd_q == WD_LAST) begin
          err_timeout_d = 1'b1;
          to_gap        = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          to_gap      = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d        = S_IDLE;
          frame_active_d = 1'b0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d        = S_IDLE;
        frame_active_d = 1'b0;
      end
    endcase

    if (to_gap) begin
      if (GAP_CYCLES == 0) begin
        state_d        = S_IDLE;
        frame_active_d = 1'b0;
      end else begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      grant_id_q     <= '0;
      tx_data_q      <= '0;
      tx_new_data_q  <= 1'b0;
      ack_q          <= '0;
      frame_active_q <= 1'b0;
      frame_cnt_q    <= '0;
      err_timeout_q  <= 1'b0;
      gap_q          <= '0;
      wd_q           <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_id_q     <= grant_id_d;
      tx_data_q      <= tx_data_d;
      tx_new_data_q  <= tx_new_data_d;
      ack_q          <= ack_d;
      frame_active_q <= frame_active_d;
      frame_cnt_q    <= frame_cnt_d;
      err_timeout_q  <= err_timeout_d;
      gap_q          <= gap_d;
      wd_q           <= wd_d;
    end
  end

  assign tx_new_data  = tx_new_data_q;
  assign tx_data      = tx_data_q;
  assign ack          = ack_q;
  assign grant_id     = grant_id_q;
  assign frame_active = frame_active_q;
  assign frame_cnt    = frame_cnt_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_serial_tx_sched.sv
// Bench for serial_tx_sched: transmitter model plus a grant/data
// scoreboard popped on every launch strobe.
module tb_serial_tx_sched;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TMO = 8;
  localparam int FR  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [48*N-1:0] req_data;
  logic           pause;
  logic           tx_busy;
  logic           busy_model;
  logic           busy_force;
  logic           tx_new_data;
  logic [47:0]    tx_data;
  logic [N-1:0]   ack;
  logic [1:0]     grant_id;
  logic           frame_active;
  logic [15:0]    frame_cnt;
  logic           err_timeout;
  bit             tx_en;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ch;
    logic [47:0] d;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [47:0] chdat[N];

  always #5 clk = ~clk;

  assign tx_busy = busy_model | busy_force;

  serial_tx_sched #(
    .NUM_REQ     (N),
    .GAP_CYCLES  (GAP),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .pause       (pause),
    .tx_busy     (tx_busy),
    .tx_new_data (tx_new_data),
    .tx_data     (tx_data),
    .ack         (ack),
    .grant_id    (grant_id),
    .frame_active(frame_active),
    .frame_cnt   (frame_cnt),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch);
    exp_t e;
    e.ch = ch;
    e.d  = chdat[ch];
    sb.push_back(e);
  endtask

  task automatic wait_strobe(input string tag, input int budget,
                             output int ch, output int lat);
    ch  = -1;
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tx_new_data) begin
        ch  = int'(grant_id);
        lat = i;
        break;
      end
    end
    chk(tag, ch >= 0, 1);
  endtask

  task automatic wait_fall(input string tag, input int budget);
    bit seen1 = 0;
    bit got   = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_busy) seen1 = 1;
      else if (seen1) begin
        got = 1;
        break;
      end
    end
    chk(tag, got, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!frame_active) begin
        got = 1;
        break;
      end
    end
    chk(tag, got, 1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit q = 1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_new_data) q = 0;
    end
    chk(tag, q, 1);
  endtask

  // Transmitter: busy rises just after a seen strobe, lasts FR clocks.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_new_data && tx_en) begin
        #2 busy_model = 1'b1;
        repeat (FR) @(negedge clk);
        #2 busy_model = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_new_data || ack != '0)
        chk("ack_onehot", ack,
            tx_new_data ? (4'b0001 << grant_id) : 4'b0000);
      if (tx_new_data) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_grant", grant_id, mon_e.ch);
          chk("sb_data", tx_data, mon_e.d);
        end
      end
    end
  end

  initial begin
    int ch;
    int lat;

    chdat[0] = 48'h010203040506;
    chdat[1] = 48'h111122223333;
    chdat[2] = 48'hA5A55A5A0F0F;
    chdat[3] = 48'hDEADBEEFCAFE;
    req_data   = {chdat[3], chdat[2], chdat[1], chdat[0]};
    req        = '0;
    pause      = 1'b0;
    busy_force = 1'b0;
    tx_en      = 1'b1;
    rst        = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_strobe", tx_new_data, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;

    // single frame, then a back-to-back re-request to measure the gap
    push(0);
    push(0);
    req = 4'b0001;
    wait_strobe("t1_s1", 10, ch, lat);
    chk("t1_lat", lat, 1);
    wait_fall("t1_fall1", 20);
    chk("t1_cnt1", frame_cnt, 1);
    chk("t1_active_gap", frame_active, 1);
    wait_strobe("t1_s2", 20, ch, lat);
    // clocks from tx_busy fall to strobe, counting the sampling edge
    chk("t1_spacing", lat + 1, GAP + 2);
    req = '0;
    req_data[47:0] = '0;
    repeat (2) @(negedge clk);
    chk("t1_hold", tx_data, chdat[0]);
    req_data[47:0] = chdat[0];
    wait_fall("t1_fall2", 20);
    chk("t1_cnt2", frame_cnt, 2);
    repeat (GAP - 1) @(negedge clk);
    chk("t1_gap_end", frame_active, 1);
    @(negedge clk);
    chk("t1_idle", frame_active, 0);

    // fairness from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(0); push(1); push(2); push(3); push(0); push(1);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_strobe("t2_s", 40, ch, lat);
      if (ch >= 0) req[ch] = 1'b0;
      @(negedge clk);
      if (k == 5) req = '0;
      else if (ch >= 0) req[ch] = 1'b1;
    end
    wait_idle("t2_idle", 40);
    chk("t2_cnt", frame_cnt, 6);
    chk("t2_sb", sb.size(), 0);

    // sparse requests after a channel-1 grant
    push(3);
    push(1);
    req = 4'b1010;
    wait_strobe("t3_s1", 40, ch, lat);
    chk("t3_first", ch, 3);
    if (ch >= 0) req[ch] = 1'b0;
    wait_strobe("t3_s2", 40, ch, lat);
    chk("t3_second", ch, 1);
    req = '0;
    wait_idle("t3_idle", 40);
    chk("t3_cnt", frame_cnt, 8);

    // busy never rises: watchdog, then regrant
    tx_en = 1'b0;
    push(2);
    push(2);
    req = 4'b0100;
    wait_strobe("t4_s1", 40, ch, lat);
    repeat (TMO) @(negedge clk);
    chk("t4_err_early", err_timeout, 0);
    @(negedge clk);
    chk("t4_err_set", err_timeout, 1);
    chk("t4_cnt_hold", frame_cnt, 8);
    tx_en = 1'b1;
    wait_strobe("t4_s2", 40, ch, lat);
    req = '0;
    wait_fall("t4_fall", 20);
    chk("t4_cnt", frame_cnt, 9);
    chk("t4_sticky", err_timeout, 1);
    wait_idle("t4_idle", 40);

    // transmitter held busy externally while idle
    busy_force = 1'b1;
    push(1);
    req = 4'b0010;
    quiet("t7_blocked", 10);
    busy_force = 1'b0;
    wait_strobe("t7_s", 3, ch, lat);
    chk("t7_lat", lat, 1);
    req = '0;
    wait_fall("t7_fall", 20);
    wait_idle("t7_idle", 40);
    chk("t7_cnt", frame_cnt, 10);

    // pause
    pause = 1'b1;
    push(2);
    req = 4'b0100;
    quiet("t5_paused", 50);
    pause = 1'b0;
    wait_strobe("t5_s1", 2, ch, lat);
    repeat (2) @(negedge clk);
    chk("t5_in_frame", tx_busy, 1);
    pause = 1'b1;
    wait_fall("t5_fall", 20);
    chk("t5_cnt", frame_cnt, 11);
    quiet("t5_parked", 30);
    chk("t5_park_idle", frame_active, 0);
    push(2);
    pause = 1'b0;
    wait_strobe("t5_s2", 2, ch, lat);
    req = '0;
    wait_fall("t5_fall2", 20);
    wait_idle("t5_idle", 40);
    chk("t5_cnt2", frame_cnt, 12);

    // asynchronous reset in the middle of a frame
    push(3);
    req = 4'b1000;
    wait_strobe("t6_s1", 5, ch, lat);
    req = '0;
    repeat (2) @(negedge clk);
    chk("t6_busy", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_strobe", tx_new_data, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_ack", ack, 0);
    chk("t6_gid", grant_id, 0);
    chk("t6_active", frame_active, 0);
    chk("t6_cnt", frame_cnt, 0);
    chk("t6_err", err_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    push(0);
    push(3);
    req = 4'b1001;
    wait_strobe("t6_s2", 20, ch, lat);
    chk("t6_first", ch, 0);
    req = 4'b1000;
    wait_strobe("t6_s3", 40, ch, lat);
    req = '0;
    wait_fall("t6_fall", 20);
    chk("t6_cnt2", frame_cnt, 2);
    wait_idle("t6_idle", 40);
    chk("t6_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
